// File: rtl/reg_writeback_pkg.sv
// Shared widths and the queued-write entry type for the register write-back path.
package reg_wb_pkg;
  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NREG = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0] id;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_if.sv
// Result handshakes, register-file write port and forwarding lookups of the write-back block.
interface reg_writeback_if #(parameter int DEPTH = 4);
  import reg_wb_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic            ALU_Valid;
  logic            ALU_Ready;
  logic [AW-1:0]   ALU_ID;
  logic [DW-1:0]   ALU_Data;
  logic            MEM_Valid;
  logic            MEM_Ready;
  logic [AW-1:0]   MEM_ID;
  logic [DW-1:0]   MEM_Data;
  logic [AW-1:0]   REG_W_ID;
  logic            Reg_WE;
  logic [DW-1:0]   Reg_WData;
  logic [AW-1:0]   RS_ID;
  logic [AW-1:0]   RT_ID;
  logic            Fwd_Hit1;
  logic [DW-1:0]   Fwd_Data1;
  logic            Fwd_Hit2;
  logic [DW-1:0]   Fwd_Data2;
  logic [NREG-1:0] Pend_Mask;
  logic [CW-1:0]   Count;

  modport master (
    output ALU_Valid, ALU_ID, ALU_Data, MEM_Valid, MEM_ID, MEM_Data, RS_ID, RT_ID,
    input  ALU_Ready, MEM_Ready, REG_W_ID, Reg_WE, Reg_WData,
           Fwd_Hit1, Fwd_Data1, Fwd_Hit2, Fwd_Data2, Pend_Mask, Count
  );

  modport slave (
    input  ALU_Valid, ALU_ID, ALU_Data, MEM_Valid, MEM_ID, MEM_Data, RS_ID, RT_ID,
    output ALU_Ready, MEM_Ready, REG_W_ID, Reg_WE, Reg_WData,
           Fwd_Hit1, Fwd_Data1, Fwd_Hit2, Fwd_Data2, Pend_Mask, Count
  );
endinterface

// File: rtl/reg_writeback_fifo.sv
// Circular write queue exporting its contents in age order (index 0 = head); 1-cycle push-to-head.
// Backpressure: caller must not push when full; push/pop outside legal occupancy are ignored.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    push,
  input  wb_entry_t               push_dat,
  input  logic                    pop,
  output logic [CW-1:0]           count,
  output wb_entry_t [DEPTH-1:0]   ord,
  output logic [DEPTH-1:0]        ord_vld
);
  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Rotate storage so consumers see entries oldest-first without pointer math.
  always_comb begin
    rd_idx  = '0;
    ord     = '0;
    ord_vld = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_idx     = rd_ptr + PW'(k);
      ord[k]     = mem[rd_idx];
      ord_vld[k] = CW'(k) < count;
    end
  end
endmodule

// File: rtl/reg_writeback.sv
// Arbitrates ALU/MEM results into an in-order write queue, one register write per cycle (1-cycle latency).
// Backpressure: ALU has fixed priority; both Readys drop when full, regardless of a same-cycle drain.
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic            CLK,
  input logic            RST,
  reg_writeback_if.slave wb
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  has_room;
  logic                  push;
  logic                  pop;
  wb_entry_t             push_dat;
  logic [CW-1:0]         count;
  wb_entry_t [DEPTH-1:0] ord;
  logic [DEPTH-1:0]      ord_vld;
  logic [NREG-1:0]       pend;
  logic                  hit1;
  logic                  hit2;
  logic [DW-1:0]         fwd1;
  logic [DW-1:0]         fwd2;

  assign has_room     = !RST && (count < CW'(DEPTH));
  assign wb.ALU_Ready = has_room;
  assign wb.MEM_Ready = has_room && !wb.ALU_Valid;
  assign push         = (wb.ALU_Valid && wb.ALU_Ready) || (wb.MEM_Valid && wb.MEM_Ready);
  assign push_dat     = wb.ALU_Valid ? '{id: wb.ALU_ID, data: wb.ALU_Data}
                                     : '{id: wb.MEM_ID, data: wb.MEM_Data};
  // The register file never stalls, so any occupied head retires this edge.
  assign pop          = (count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .count    (count),
    .ord      (ord),
    .ord_vld  (ord_vld)
  );

  assign wb.Count     = count;
  assign wb.Reg_WE    = pop;
  assign wb.REG_W_ID  = ord_vld[0] ? ord[0].id   : '0;
  assign wb.Reg_WData = ord_vld[0] ? ord[0].data : '0;

  // Scan oldest to youngest so the last match wins the forwarding mux.
  always_comb begin
    pend = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ord_vld[k]) begin
        pend[ord[k].id] = 1'b1;
        if (ord[k].id == wb.RS_ID) begin
          hit1 = 1'b1;
          fwd1 = ord[k].data;
        end
        if (ord[k].id == wb.RT_ID) begin
          hit2 = 1'b1;
          fwd2 = ord[k].data;
        end
      end
    end
  end

  assign wb.Pend_Mask = pend;
  assign wb.Fwd_Hit1  = hit1;
  assign wb.Fwd_Data1 = fwd1;
  assign wb.Fwd_Hit2  = hit2;
  assign wb.Fwd_Data2 = fwd2;
endmodule

// File: tb/tb_reg_writeback.sv
// Randomized and directed bench for reg_writeback against a queue-based reference model.
module tb_reg_writeback;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  reg_writeback_if #(.DEPTH(4)) bus ();

  reg_writeback #(.DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .wb  (bus.slave)
  );

  typedef struct {
    logic [2:0]  id;
    logic [15:0] data;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  bit          av, mv;
  logic [2:0]  aid, mid, rs, rt;
  logic [15:0] ad, md;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int          n;
    bit          rdy;
    logic [7:0]  mask;
    bit          h1, h2;
    logic [15:0] d1, d2;
    bit          f1, f2;
    n   = q.size();
    rdy = !RST && (n < 4);
    chk("alu_ready", bus.ALU_Ready, rdy);
    chk("mem_ready", bus.MEM_Ready, rdy && !av);
    chk("count", bus.Count, n);
    chk("reg_we", bus.Reg_WE, n != 0);
    if (n != 0) begin
      chk("reg_w_id", bus.REG_W_ID, q[0].id);
      chk("reg_wdata", bus.Reg_WData, q[0].data);
    end else begin
      chk("reg_w_id", bus.REG_W_ID, 0);
      chk("reg_wdata", bus.Reg_WData, 0);
    end
    mask = '0;
    foreach (q[i]) mask[q[i].id] = 1'b1;
    h1 = 0; h2 = 0; d1 = '0; d2 = '0; f1 = 0; f2 = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!f1 && q[i].id == rs) begin f1 = 1; h1 = 1; d1 = q[i].data; end
      if (!f2 && q[i].id == rt) begin f2 = 1; h2 = 1; d2 = q[i].data; end
    end
    chk("pend_mask", bus.Pend_Mask, mask);
    chk("fwd_hit1", bus.Fwd_Hit1, h1);
    chk("fwd_data1", bus.Fwd_Data1, d1);
    chk("fwd_hit2", bus.Fwd_Hit2, h2);
    chk("fwd_data2", bus.Fwd_Data2, d2);
  endtask

  // One cycle: drive inputs, check combinational view, then apply the edge to the model.
  task automatic tick();
    bit rdy;
    bit acc_a, acc_m;
    bus.ALU_Valid = av;  bus.ALU_ID = aid; bus.ALU_Data = ad;
    bus.MEM_Valid = mv;  bus.MEM_ID = mid; bus.MEM_Data = md;
    bus.RS_ID = rs;      bus.RT_ID = rt;
    #1;
    if (RST) q.delete();
    check_outputs();
    rdy   = !RST && (q.size() < 4);
    acc_a = av && rdy;
    acc_m = mv && rdy && !av;
    @(posedge CLK);
    if (!RST) begin
      if (q.size() != 0) void'(q.pop_front());
      if (acc_a) q.push_back('{id: aid, data: ad});
      else if (acc_m) q.push_back('{id: mid, data: md});
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    av = 0; mv = 0;
  endtask

  initial begin
    av = 1; aid = 3'd3; ad = 16'd123;
    mv = 0; mid = '0; md = '0; rs = 3'd3; rt = 3'd0;
    @(negedge CLK);
    tick();
    RST = 1'b0;

    // Single ALU write and its one-cycle latency
    tick();
    idle(); tick(); tick();

    // Contention: ALU wins, MEM follows
    av = 1; aid = 3'd2; ad = 16'h0011;
    mv = 1; mid = 3'd5; md = 16'h0022;
    tick();
    av = 0; tick();
    idle(); tick(); tick();

    // Back-to-back ALU pushes, drained in order
    for (int i = 1; i <= 4; i++) begin
      av = 1; aid = 3'(i); ad = 16'(16'h100 + i);
      tick();
    end
    idle(); tick(); tick();

    // Same destination twice: youngest data forwarded
    rs = 3'd6; rt = 3'd0;
    av = 1; aid = 3'd6; ad = 16'hAAAA; tick();
    av = 1; aid = 3'd6; ad = 16'hBBBB; tick();
    idle(); tick(); tick();

    // Sustained traffic across pointer wrap, alternating sources
    for (int i = 0; i < 10; i++) begin
      av = (i % 2) == 0; aid = 3'($urandom); ad = 16'($urandom);
      mv = 1;            mid = 3'($urandom); md = 16'($urandom);
      rs = 3'($urandom); rt = 3'($urandom);
      tick();
    end
    idle(); tick();

    // Reset pulsed between edges discards the pending write
    av = 1; aid = 3'd7; ad = 16'h7777; tick();
    idle();
    RST = 1'b1;
    #1;
    q.delete();
    chk("rst_count", bus.Count, 0);
    chk("rst_we", bus.Reg_WE, 0);
    chk("rst_pend", bus.Pend_Mask, 0);
    chk("rst_alu_ready", bus.ALU_Ready, 0);
    #1 RST = 1'b0;
    tick(); tick();

    // Random traffic with occasional full-cycle resets
    for (int i = 0; i < 400; i++) begin
      av  = ($urandom_range(0, 99) < 50);
      mv  = ($urandom_range(0, 99) < 50);
      aid = 3'($urandom); ad = 16'($urandom);
      mid = 3'($urandom); md = 16'($urandom);
      rs  = 3'($urandom); rt = 3'($urandom);
      RST = ($urandom_range(0, 49) == 0);
      tick();
      RST = 1'b0;
    end
    idle(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
